// File: rtl/circular_buffer_pkg.sv
// Shared flit types for the router input buffers.
// Exports FLIT_DATA_SIZE, flit_label_t and the flit_Data_noVC flit bundle.
package circular_buffer_pkg;

    localparam int FLIT_DATA_SIZE = 32;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t               flit_label;
        logic [FLIT_DATA_SIZE-1:0] data;
    } flit_Data_noVC;

endpackage

// File: rtl/circular_buffer.sv
// Router input-port flit FIFO with first-word-fall-through head and
// on/off flow control with hysteresis toward the upstream sender.
// Ports: clk; rst_n (synchronous, active-high); input_Data/write_i enqueue;
//   read_i dequeue; output_Data head flit ('0 when empty); buf_empty;
//   buf_full; buf_On_Off (1 = upstream may send).
// Option: CIRCULAR_BUFFER_OCCUPANCY_EN adds num_flits_o (current count).
module circular_buffer
    import circular_buffer_pkg::*;
#(
    parameter int BUFFER_SIZE   = 8,
    parameter int OFF_THRESHOLD = 6,
    parameter int ON_THRESHOLD  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  flit_Data_noVC input_Data,
    input  logic          write_i,
    input  logic          read_i,
    output flit_Data_noVC output_Data,
    output logic          buf_empty,
    output logic          buf_full,
    output logic          buf_On_Off
`ifdef CIRCULAR_BUFFER_OCCUPANCY_EN
    ,
    output logic [$clog2(BUFFER_SIZE+1)-1:0] num_flits_o
`endif
);

    localparam int PW = $clog2(BUFFER_SIZE);
    localparam int CW = $clog2(BUFFER_SIZE + 1);
    localparam logic [PW-1:0] LAST = PW'(BUFFER_SIZE - 1);

    flit_Data_noVC mem [BUFFER_SIZE];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] next_count;
    logic          on_off;
    logic          wr_en;
    logic          rd_en;

    assign buf_empty = (count == '0);
    assign buf_full  = (count == CW'(BUFFER_SIZE));

    // A full buffer still takes a write when the head leaves in the
    // same cycle; an empty buffer never honours a read.
    assign wr_en = write_i && (!buf_full || read_i);
    assign rd_en = read_i && !buf_empty;

    always_comb begin
        next_count = count;
        if (wr_en && !rd_en) begin
            next_count = count + 1'b1;
        end else if (rd_en && !wr_en) begin
            next_count = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            on_off <= 1'b1;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            count <= next_count;
            // Hysteresis band: between the thresholds the level holds.
            if (next_count >= CW'(OFF_THRESHOLD)) begin
                on_off <= 1'b0;
            end else if (next_count <= CW'(ON_THRESHOLD)) begin
                on_off <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst_n && wr_en) begin
            mem[wr_ptr] <= input_Data;
        end
    end

    assign output_Data = buf_empty ? '0 : mem[rd_ptr];
    assign buf_On_Off  = on_off;

`ifdef CIRCULAR_BUFFER_OCCUPANCY_EN
    assign num_flits_o = count;
`endif

endmodule

// File: tb/tb_circular_buffer.sv
// Self-checking bench for circular_buffer (BUFFER_SIZE=8, OFF=6, ON=2).
// Directed scenarios followed by randomized traffic against a queue model.
module tb_circular_buffer;
    import circular_buffer_pkg::*;

    localparam int SZ  = 8;
    localparam int OFF = 6;
    localparam int ON  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    flit_Data_noVC input_Data;
    logic          write_i;
    logic          read_i;
    flit_Data_noVC output_Data;
    logic          buf_empty;
    logic          buf_full;
    logic          buf_On_Off;
`ifdef CIRCULAR_BUFFER_OCCUPANCY_EN
    logic [3:0]    num_flits_o;
`endif

    circular_buffer #(
        .BUFFER_SIZE  (SZ),
        .OFF_THRESHOLD(OFF),
        .ON_THRESHOLD (ON)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .input_Data (input_Data),
        .write_i    (write_i),
        .read_i     (read_i),
        .output_Data(output_Data),
        .buf_empty  (buf_empty),
        .buf_full   (buf_full),
        .buf_On_Off (buf_On_Off)
`ifdef CIRCULAR_BUFFER_OCCUPANCY_EN
        ,
        .num_flits_o(num_flits_o)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a queue of stored flits plus the flow-control level.
    flit_Data_noVC q[$];
    bit            mon = 1'b1;

    task automatic check(string tag, logic [33:0] got, logic [33:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic flit_Data_noVC mk(logic [31:0] v);
        flit_Data_noVC f;
        f.flit_label = BODY;
        f.data       = v;
        return f;
    endfunction

    task automatic check_all();
        flit_Data_noVC head;
        head = (q.size() != 0) ? q[0] : '0;
        check("empty", 34'(buf_empty), 34'(q.size() == 0));
        check("full", 34'(buf_full), 34'(q.size() == SZ));
        check("on_off", 34'(buf_On_Off), 34'(mon));
        check("head", output_Data, head);
`ifdef CIRCULAR_BUFFER_OCCUPANCY_EN
        check("occupancy", 34'(num_flits_o), 34'(q.size()));
`endif
    endtask

    // One clock: drive inputs, advance the model at the edge, then compare.
    task automatic step(bit rst, bit w, bit r, flit_Data_noVC d);
        bit wacc;
        bit racc;
        rst_n      = rst;
        write_i    = w;
        read_i     = r;
        input_Data = d;
        @(posedge clk);
        if (rst) begin
            q.delete();
            mon = 1'b1;
        end else begin
            wacc = w && (q.size() < SZ || r);
            racc = r && (q.size() > 0);
            if (racc) void'(q.pop_front());
            if (wacc) q.push_back(d);
            if (q.size() >= OFF) mon = 1'b0;
            else if (q.size() <= ON) mon = 1'b1;
        end
        #1;
        check_all();
    endtask

    flit_Data_noVC rf;
    int            wp;

    initial begin
        rst_n      = 1'b1;
        write_i    = 1'b0;
        read_i     = 1'b0;
        input_Data = '0;

        // Reset
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        check("rst_empty", 34'(buf_empty), 34'd1);
        check("rst_full", 34'(buf_full), 34'd0);
        check("rst_onoff", 34'(buf_On_Off), 34'd1);
        check("rst_data", output_Data, 34'd0);

        // Fill, overflow attempt, drain
        for (int i = 0; i < 8; i++) step(0, 1, 0, mk(32'h10 + i));
        check("fill_full", 34'(buf_full), 34'd1);
        step(0, 1, 0, mk(32'h18));
        for (int i = 0; i < 8; i++) begin
            check("drain_order", 34'(output_Data.data), 34'(32'h10 + i));
            step(0, 0, 1, '0);
        end
        check("drain_empty", 34'(buf_empty), 34'd1);

        // Wrap across the last slot
        for (int i = 0; i < 5; i++) step(0, 1, 0, mk(32'h20 + i));
        for (int i = 0; i < 5; i++) step(0, 0, 1, '0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, mk(32'h30 + i));
        for (int i = 0; i < 8; i++) begin
            check("wrap_order", 34'(output_Data.data), 34'(32'h30 + i));
            step(0, 0, 1, '0);
        end

        // Simultaneous read+write when full, then when empty
        for (int i = 0; i < 8; i++) step(0, 1, 0, mk(32'h40 + i));
        step(0, 1, 1, mk(32'hAA));
        check("rw_full_stays", 34'(buf_full), 34'd1);
        check("rw_full_head", 34'(output_Data.data), 34'h41);
        for (int i = 0; i < 7; i++) step(0, 0, 1, '0);
        check("rw_full_last", 34'(output_Data.data), 34'hAA);
        step(0, 0, 1, '0);
        step(0, 1, 1, mk(32'h55));
        check("rw_empty_data", 34'(output_Data.data), 34'h55);
        check("rw_empty_nonempty", 34'(buf_empty), 34'd0);
        step(0, 0, 1, '0);

        // On/off hysteresis
        for (int i = 0; i < 5; i++) step(0, 1, 0, mk(32'h60 + i));
        check("onoff_at5", 34'(buf_On_Off), 34'd1);
        step(0, 1, 0, mk(32'h65));
        check("onoff_at6", 34'(buf_On_Off), 34'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, '0);
        check("onoff_at3", 34'(buf_On_Off), 34'd0);
        step(0, 0, 1, '0);
        check("onoff_at2", 34'(buf_On_Off), 34'd1);

        // Reset mid-fill at count 5 with a read pending
        for (int i = 0; i < 3; i++) step(0, 1, 0, mk(32'h70 + i));
        step(1, 0, 1, '0);
        check("midrst_empty", 34'(buf_empty), 34'd1);
        check("midrst_onoff", 34'(buf_On_Off), 34'd1);
        step(0, 0, 1, '0);
        step(0, 1, 0, mk(32'h77));
        check("midrst_data", 34'(output_Data.data), 34'h77);

        // Randomized traffic, alternating write-heavy and read-heavy phases
        for (int n = 0; n < 600; n++) begin
            wp = ((n / 40) % 2 == 0) ? 80 : 25;
            rf.flit_label = flit_label_t'($urandom_range(0, 3));
            rf.data       = $urandom;
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < wp,
                 $urandom_range(0, 99) < (100 - wp),
                 rf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
